// File: rtl/mem_master.sv
// mem_master: request sequencer in front of the wait-state RAM.
// Commands are queued in a small FIFO, issued to the RAM one at a time,
// held until the RAM's ready (or a watchdog abort), and answered on a
// valid/ready response channel. All mem_* and rsp_* outputs are registered.
module mem_master #(
    parameter int FIFO_DEPTH = 4,   // power of two, 2..16
    parameter int TIMEOUT    = 15   // 1..255 cycles of mem_ready wait
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_write,
    output logic       rsp_err,
    output logic [7:0] mem_addr,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_wdata,
    input  logic       mem_ready,
    input  logic [7:0] mem_rdata
);

    localparam int             AW           = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_COUNT   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]     TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Command FIFO
    cmd_t          fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    cmd_t          head;

    // FSM and registered outputs, with their next-state values
    state_t     state, state_n;
    logic [7:0] timer, timer_n;
    logic [7:0] mem_addr_n, mem_wdata_n;
    logic       mem_read_n, mem_write_n;
    logic       rsp_valid_n, rsp_write_n, rsp_err_n;
    logic [7:0] rsp_rdata_n;

    assign cmd_ready = (count != FULL_COUNT);
    assign push      = cmd_valid && cmd_ready;
    assign head      = fifo_mem[rd_ptr];

    // FIFO storage: written on push only.
    // NOTE: the storage array has no reset; validity is tracked by count, so
    // clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Next-state and next-output logic for the transaction sequencer.
    // NOTE: every signal gets a default first (hold its register), which
    // keeps this block free of inferred latches.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_read_n  = mem_read;
        mem_write_n = mem_write;
        rsp_valid_n = rsp_valid;
        rsp_rdata_n = rsp_rdata;
        rsp_write_n = rsp_write;
        rsp_err_n   = rsp_err;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop         = 1'b1;
                    mem_addr_n  = head.addr;
                    mem_wdata_n = head.wdata;
                    mem_read_n  = !head.write;
                    mem_write_n = head.write;
                    timer_n     = '0;
                    state_n     = REQ;
                end
            end

            REQ: begin
                if (mem_ready) begin
                    // mem_rdata is only trusted in this cycle, and only for reads.
                    rsp_rdata_n = mem_write ? 8'h00 : mem_rdata;
                    rsp_write_n = mem_write;
                    rsp_err_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    mem_read_n  = 1'b0;
                    mem_write_n = 1'b0;
                    state_n     = RESP;
                end else if (timer == TIMEOUT_LAST) begin
                    // Watchdog abort: drop the request and report an error.
                    rsp_rdata_n = 8'h00;
                    rsp_write_n = mem_write;
                    rsp_err_n   = 1'b1;
                    rsp_valid_n = 1'b1;
                    mem_read_n  = 1'b0;
                    mem_write_n = 1'b0;
                    state_n     = RESP;
                end else begin
                    timer_n = timer + 8'd1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, watchdog timer and all registered mem_*/rsp_* outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_read  <= mem_read_n;
            mem_write <= mem_write_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_write <= rsp_write_n;
            rsp_err   <= rsp_err_n;
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed, table-driven bench for mem_master with a
// behavioural wait-state RAM (ready after W cycles of a held request).
module tb_mem_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_write;
    logic       rsp_err;
    logic [7:0] mem_addr;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic       mem_ready;
    logic [7:0] mem_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    mem_master #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- wait-state RAM model ----------------
    // Unwritten locations read as addr ^ 0x5C.
    logic [7:0]  ram     [256];
    bit          ram_vld [256];
    int unsigned wait_cnt = 0;
    int unsigned ram_w    = 0;
    bit          ram_en   = 1'b1;
    logic        mem_req;
    logic [7:0]  ram_val;

    assign mem_req   = mem_read | mem_write;
    assign mem_ready = ram_en && mem_req && (wait_cnt == ram_w);
    assign ram_val   = ram_vld[mem_addr] ? ram[mem_addr] : (mem_addr ^ 8'h5C);
    assign mem_rdata = mem_ready ? ram_val : 8'hxx;

    always @(posedge clk) begin
        wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
        if (mem_ready && mem_write) begin
            ram[mem_addr]     <= mem_wdata;
            ram_vld[mem_addr] <= 1'b1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Response scoreboard: every completed handshake is logged.
    typedef struct packed {
        logic       write;
        logic       err;
        logic [7:0] rdata;
    } rsp_t;

    rsp_t rsp_q[$];

    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready)
            rsp_q.push_back('{write: rsp_write, err: rsp_err, rdata: rsp_rdata});
    end

    // After a mem_ready cycle the request must be low for at least one cycle.
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_done <= 1'b0;
        end else begin
            if (prev_done) check("mem_gap", {31'd0, mem_req}, 32'd0);
            prev_done <= mem_req && mem_ready;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_cmd(input logic w, input logic [7:0] a, input logic [7:0] d,
                            output int acc);
        acc       = -1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = int'(cyc);
                break;
            end
        end
        if (acc < 0) bound_fail("push_accept");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        rsp_q.delete();
    endtask

    task automatic wait_rsps(input int n, input string name);
        int k;
        k = 0;
        while (rsp_q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (rsp_q.size() < n) bound_fail(name);
        repeat (5) @(negedge clk);
        check({name, "_count"}, rsp_q.size(), n);
    endtask

    task automatic wait_rsp_valid(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!rsp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!rsp_valid) bound_fail(name);
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t t2[6];
    vec_t t6[6];

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int acc_t[6];
        int a0;
        int a1;
        int cnt;
        int rv_cyc;
        int bad;

        t2[0] = '{1'b1, 8'h56, 8'h11, 8'h00, 1'b0};
        t2[1] = '{1'b1, 8'h78, 8'h22, 8'h00, 1'b0};
        t2[2] = '{1'b1, 8'h9a, 8'h33, 8'h00, 1'b0};
        t2[3] = '{1'b0, 8'h56, 8'h00, 8'h11, 1'b0};
        t2[4] = '{1'b0, 8'h78, 8'h00, 8'h22, 1'b0};
        t2[5] = '{1'b0, 8'h9a, 8'h00, 8'h33, 1'b0};
        for (int i = 0; i < 6; i++)
            t6[i] = '{1'b0, 8'hC0 + 8'(i), 8'h00, (8'hC0 + 8'(i)) ^ 8'h5C, 1'b0};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b1;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("reset_rsp", {cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        check("reset_mem", {mem_read, mem_write, mem_addr, mem_wdata},
              {1'b0, 1'b0, 8'h00, 8'h00});
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // ---- W=0: write then read, latency 2 / 3 ----
        ram_w = 0;
        push_cmd(1'b1, 8'h34, 8'h5A, a0);
        @(negedge clk);
        check("t1_no_bypass", {mem_read, mem_write}, 2'b00);
        @(negedge clk);
        check("t1_wr_req", {mem_read, mem_write, mem_addr, mem_wdata},
              {1'b0, 1'b1, 8'h34, 8'h5A});
        @(negedge clk);
        check("t1_wr_rsp", {rsp_valid, rsp_write, rsp_err, rsp_rdata},
              {1'b1, 1'b1, 1'b0, 8'h00});
        @(posedge clk);
        #1;
        push_cmd(1'b0, 8'h34, 8'h00, a0);
        @(negedge clk);
        @(negedge clk);
        check("t1_rd_req", {mem_read, mem_write, mem_addr}, {1'b1, 1'b0, 8'h34});
        @(negedge clk);
        check("t1_rd_rsp", {rsp_valid, rsp_write, rsp_err, rsp_rdata},
              {1'b1, 1'b0, 1'b0, 8'h5A});

        // ---- W=4, six back-to-back commands, FIFO fills ----
        do_reset();
        ram_w = 4;
        for (int i = 0; i < 6; i++)
            push_cmd(t2[i].write, t2[i].addr, t2[i].wdata, acc_t[i]);
        check("t2_first5_no_stall", acc_t[4] - acc_t[0], 4);
        check("t2_full_stall", acc_t[5] - acc_t[4], 5);
        wait_rsps(6, "t2_rsp");
        for (int i = 0; i < 6 && i < rsp_q.size(); i++)
            check($sformatf("t2_rsp%0d", i), rsp_q[i],
                  {t2[i].write, t2[i].exp_err, t2[i].exp_rdata});

        // ---- W=2, response held off for 10 cycles ----
        do_reset();
        ram_w     = 2;
        rsp_ready = 1'b0;
        push_cmd(1'b1, 8'h10, 8'h77, a0);
        push_cmd(1'b0, 8'h10, 8'h00, a1);
        wait_rsp_valid("t3_first_rsp");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if ({rsp_valid, rsp_write, rsp_err, rsp_rdata, mem_read, mem_write} !==
                {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) bad++;
        end
        check("t3_stable_cycles_bad", bad, 0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("t3_accept_cycle_noreq", {mem_read, mem_write}, 2'b00);
        @(negedge clk);
        check("t3_idle_cycle_noreq", {mem_read, mem_write}, 2'b00);
        @(negedge clk);
        check("t3_reissue", {mem_read, mem_addr}, {1'b1, 8'h10});
        wait_rsps(2, "t3_rsp");
        if (rsp_q.size() == 2) begin
            check("t3_rsp0", rsp_q[0], {1'b1, 1'b0, 8'h00});
            check("t3_rsp1", rsp_q[1], {1'b0, 1'b0, 8'h77});
        end

        // ---- watchdog: RAM never ready ----
        do_reset();
        ram_en = 1'b0;
        ram_w  = 1;
        push_cmd(1'b0, 8'h00, 8'h00, a0);
        push_cmd(1'b1, 8'h05, 8'hC3, a1);
        cnt    = 0;
        rv_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_read) cnt++;
            if (rsp_valid) begin
                rv_cyc = int'(cyc);
                check("t4_err_rsp", {rsp_write, rsp_err, rsp_rdata}, {1'b0, 1'b1, 8'h00});
                ram_en = 1'b1;
                break;
            end
        end
        if (rv_cyc < 0) bound_fail("t4_timeout_rsp");
        check("t4_read_high_cycles", cnt, 15);
        check("t4_rsp_latency", rv_cyc - a0, 17);
        wait_rsps(2, "t4_rsp");
        if (rsp_q.size() == 2)
            check("t4_next_cmd", rsp_q[1], {1'b1, 1'b0, 8'h00});

        // ---- async reset mid-REQ, W=3, three queued ----
        do_reset();
        ram_w = 3;
        for (int i = 0; i < 4; i++)
            push_cmd(1'b0, 8'h20 + 8'(i), 8'h00, acc_t[i]);
        @(negedge clk);
        check("t5_in_req", {mem_read, mem_addr}, {1'b1, 8'h20});
        #2 reset = 1'b1;
        #1;
        check("t5_async_drop", {mem_read, mem_write, rsp_valid, cmd_ready}, 4'b0001);
        @(negedge clk);
        #2 reset = 1'b0;
        rsp_q.delete();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req || rsp_valid || !cmd_ready) bad++;
        end
        check("t5_quiet_cycles_bad", bad, 0);
        @(posedge clk);
        #1;
        push_cmd(1'b0, 8'h24, 8'h00, a0);
        wait_rsps(1, "t5_rsp");
        if (rsp_q.size() == 1)
            check("t5_fresh_rsp", rsp_q[0], {1'b0, 1'b0, 8'h24 ^ 8'h5C});

        // ---- simultaneous push/pop at full-minus-one ----
        do_reset();
        ram_w     = 0;
        rsp_ready = 1'b0;
        push_cmd(t6[0].write, t6[0].addr, t6[0].wdata, acc_t[0]);
        wait_rsp_valid("t6_first_rsp");
        @(posedge clk);
        #1;
        for (int i = 1; i < 4; i++)
            push_cmd(t6[i].write, t6[i].addr, t6[i].wdata, acc_t[i]);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = t6[4].write;
        cmd_addr  = t6[4].addr;
        cmd_wdata = t6[4].wdata;
        @(negedge clk);
        check("t6_ready_at_3", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_write = t6[5].write;
        cmd_addr  = t6[5].addr;
        cmd_wdata = t6[5].wdata;
        @(negedge clk);
        check("t6_ready_after_pushpop", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("t6_full", {31'd0, cmd_ready}, 32'd0);
        wait_rsps(6, "t6_rsp");
        for (int i = 0; i < 6 && i < rsp_q.size(); i++)
            check($sformatf("t6_rsp%0d", i), rsp_q[i],
                  {t6[i].write, t6[i].exp_err, t6[i].exp_rdata});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Request sequencer that sits directly upstream of the wait-state RAM.
- Accepts byte read/write commands on a valid/ready channel and buffers them in a small FIFO.
- Drives the RAM's addr/read/write/writedata pins one transaction at a time and holds the request until the RAM's ready.
- Returns read data or a write acknowledge on a valid/ready response channel; a watchdog aborts transactions the RAM never completes.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16.
- TIMEOUT, 15, max cycles a request is held awaiting mem_ready before abort; 1..255.

Ports:
- clk  input  1  clock; all state on posedge.
- reset  input  1  asynchronous active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  8  RAM address.
- cmd_wdata  input  8  write data; ignored for reads.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  8  read data; 0 for writes and errors.
- rsp_write  output  1  echo of the command type.
- rsp_err  output  1  transaction timed out.
- mem_addr  output  8  to RAM addr.
- mem_read  output  1  to RAM read.
- mem_write  output  1  to RAM write.
- mem_wdata  output  8  to RAM writedata.
- mem_ready  input  1  from RAM ready.
- mem_rdata  input  8  from RAM readdata; valid only while mem_ready=1, X otherwise.

Behaviour:
- Reset (async, any time, including mid-transaction): FIFO emptied, FSM=IDLE, timer=0. All outputs 0 except cmd_ready=1. A held RAM request is dropped immediately.
- FIFO: push when cmd_valid&cmd_ready. Push and pop in the same cycle are allowed; count is unchanged. No bypass: a command always spends at least one cycle in the FIFO. When full, cmd_ready=0 and cmd_valid is ignored.
- All mem_* and rsp_* outputs are registered. There are no combinational paths from inputs to outputs other than cmd_ready from FIFO state.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop head, load mem_addr/mem_wdata, set mem_read=!write or mem_write=write, clear timer, go to REQ.
  - REQ: mem_* held stable. Exactly one of mem_read/mem_write is high.
    - If mem_ready=1: capture mem_rdata into rsp_rdata (reads; 0 for writes), rsp_err=0, deassert mem_read/mem_write next cycle, go to RESP.
    - Else if timer==TIMEOUT-1: deassert request, rsp_rdata=0, rsp_err=1, go to RESP.
    - Else: timer+1.
  - RESP: rsp_valid=1; rsp_rdata/rsp_write/rsp_err stable. On rsp_ready, rsp_valid=0 next cycle and go to IDLE.
- Back-to-back issue: IDLE→REQ resumes on the cycle after the response handshake. The RAM therefore always sees read/write low for at least one cycle between transactions, which its ready generator requires.
- mem_rdata is sampled only in the mem_ready cycle, never otherwise.
- Latency: command accepted at cycle 0, mem request asserted at cycle 2. With RAM wait states W (0..4), mem_ready arrives at cycle 2+W and rsp_valid at cycle 3+W. A timeout produces rsp_valid at cycle 2+TIMEOUT.
- mem_ready outside REQ is ignored.
- Timer width is 8 bits; it never wraps because it is cleared at each REQ entry.

Test Plan:
- RAM W=0: write 0x5A to 0x34, then read 0x34 → write rsp (rsp_write=1, rdata=0, err=0) at cycle 3; read rsp rdata=0x5A, err=0.
- RAM W=4, rsp_ready held 1: six commands (writes 0x11,0x22,0x33 to 0x56,0x78,0x9a, then reads of same) pushed back-to-back → cmd_ready drops after 4 queued; reads return 0x11,0x22,0x33 in order; mem_read/mem_write low ≥1 cycle between transactions.
- RAM W=2, rsp_ready held 0 for 10 cycles after the first response → rsp_valid and fields stable; no new mem request issued until accept.
- mem_ready tied 0, TIMEOUT=15: read 0x00 → mem_read high exactly 15 cycles, then rsp_err=1, rdata=0; next queued command proceeds normally.
- Async reset asserted mid-REQ with W=3 and 3 commands queued → mem_read, rsp_valid drop immediately; after release cmd_ready=1, no stale response, FIFO empty.
- Simultaneous push/pop with FIFO full-minus-one → count correct; no command lost or duplicated (scoreboard by address).
